dna_word_feeder: RTL and testbench
==================================

Name: dna_word_feeder

Overview:
Upstream feeder for the 2-bit nucleotide extraction stage.
- Buffers 32-bit reference words from an external valid/ready stream and captures one 32-bit read word per job.
- Drives the extractor's en / en_ref / en_read / ref_32 / read_32 inputs: one symbol step per en cycle, 16 steps per reference word.
- Sits between the host/DMA word source and the extraction stage; stalls cleanly when reference data runs dry.

Parameters:
FIFO_DEPTH, 8, reference-word FIFO entries (power of 2, >=2)
LEN_W, 16, width of the per-job reference word count

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start_i  in  1  job start pulse; ignored while busy_o=1
ref_words_i  in  LEN_W  number of reference words in the job; sampled on accepted start_i
ref_word_i  in  32  reference word, 16 symbols, 2 bits each
ref_valid_i  in  1  ref_word_i valid
ref_ready_o  out  1  FIFO not full; transfer on valid&&ready
read_word_i  in  32  read (query) word
read_valid_i  in  1  read_word_i valid
read_ready_o  out  1  high only in LOAD state
en_o  out  1  symbol step strobe to extractor
en_ref_o  out  1  load ref_32_o this step
en_read_o  out  1  load read_32_o this step
ref_32_o  out  32  current reference word
read_32_o  out  32  job read word
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at job end

Behaviour:
- Reset values: every output is 0, the FIFO is empty, state is IDLE, and all counters are 0.
- ref_ready_o = !fifo_full in every state. A word is pushed on ref_valid_i && ref_ready_o. The FIFO fills during IDLE, which allows prefetch.
- States and transitions:
  - IDLE: start_i with ref_words_i==0 → DONE. start_i otherwise → LOAD; latch word_left=ref_words_i.
  - LOAD: read_ready_o=1. On read_valid_i, capture read_word_i into read_32_o → RUN, with sym_cnt=0 and first_step=1.
  - RUN, sym_cnt==0 and FIFO empty: stall. en_o=0 and counters hold.
  - RUN, sym_cnt==0 and FIFO non-empty: pop the FIFO, ref_32_o<=head, en_o=1, en_ref_o=1, en_read_o=first_step, clear first_step, sym_cnt<=1.
  - RUN, sym_cnt!=0: en_o=1, en_ref_o=0, en_read_o=0, sym_cnt<=sym_cnt+1 (4-bit, wraps 15→0).
  - RUN, on the step where sym_cnt==15: word_left decrements; if word_left reaches 0 → DONE.
  - DONE: done_o=1 for one cycle → IDLE.
- Outputs en_o, en_ref_o, en_read_o, ref_32_o, read_32_o are registered. en_ref_o and en_read_o are never high without en_o.
- Timing:
  - Steady state: 16 consecutive en_o cycles per word, with no bubbles when the FIFO is non-empty at each word boundary.
  - The first en_o comes 1 cycle after the read word is captured, provided the FIFO is non-empty.
  - done_o is asserted the cycle after the last en_o.
- Boundary cases:
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, but ready is based on the registered full flag, so no push occurs that cycle.
  - Push while empty and pop not allowed: the word becomes visible next cycle (no fall-through).
  - start_i while busy is dropped.
  - rst mid-job returns to IDLE, flushes the FIFO and clears all outputs in the same edge.
- Surplus FIFO words beyond ref_words_i stay queued for the next job.

Optional Feature:
DNA_FEEDER_STALL_CNT_EN
- Defined: adds output stall_cnt_o [31:0]. It counts RUN cycles stalled on an empty FIFO, clears on accepted start_i or rst, and saturates at 2^32-1.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package dna_pkg:
  - SYMS_PER_WORD=16, SYM_W=2, WORD_W=32.
  - feeder_state_t enum {IDLE, LOAD, RUN, DONE}.
- Sub-module dna_word_fifo: synchronous FIFO with WORD_W width and FIFO_DEPTH entries, plus push/pop/full/empty/head.

Test Plan:
- Prefill 2 words (A5A5A5A5, 3C3C3C3C), start with ref_words_i=2, read=12345678 → 32 contiguous en_o; en_ref_o on steps 0 and 16 with matching ref_32_o; en_read_o on step 0 only; done_o 1 cycle after the 32nd en_o.
- ref_words_i=3, FIFO holds 1 word, 2nd word pushed 10 cycles late → en_o low exactly 10 cycles at the boundary; 48 en_o total; stall_cnt_o=10 with DNA_FEEDER_STALL_CNT_EN.
- Push 9 words with FIFO_DEPTH=8 and no job running → ref_ready_o drops after 8 pushes; 9th word held until a pop.
- start_i with ref_words_i=0 → busy_o for 1 cycle, done_o next cycle, no en_o, read_ready_o never high.
- rst asserted at step 7 of word 1 → next cycle all outputs 0, FIFO empty, IDLE; a new job runs normally afterwards.
- start_i pulsed during RUN → ignored; job length and done_o timing unchanged.

Source files
------------

// File: rtl/dna_pkg.sv
// Shared constants and state encoding for the nucleotide word feeder.
package dna_pkg;

  localparam int unsigned SYMS_PER_WORD = 16;
  localparam int unsigned SYM_W         = 2;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned SYM_CNT_W     = $clog2(SYMS_PER_WORD);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/dna_word_fifo.sv
// Synchronous reference-word FIFO with registered full/empty flags (no fall-through).
module dna_word_fifo
  import dna_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d   = (cnt_d == (AW+1)'(FIFO_DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/dna_word_feeder.sv
// Feeds reference/read words into the 2-bit extractor, one symbol step per en_o.
// Optional DNA_FEEDER_STALL_CNT_EN adds stall_cnt_o (RUN cycles stalled on an empty FIFO).
module dna_word_feeder
  import dna_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  ref_words_i,
  input  logic [WORD_W-1:0] ref_word_i,
  input  logic              ref_valid_i,
  output logic              ref_ready_o,
  input  logic [WORD_W-1:0] read_word_i,
  input  logic              read_valid_i,
  output logic              read_ready_o,
  output logic              en_o,
  output logic              en_ref_o,
  output logic              en_read_o,
  output logic [WORD_W-1:0] ref_32_o,
  output logic [WORD_W-1:0] read_32_o,
  output logic              busy_o,
`ifdef DNA_FEEDER_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              done_o
);

  feeder_state_t        state_q, state_d;
  logic [LEN_W-1:0]     word_left_q, word_left_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic                 first_step_q, first_step_d;
  logic                 en_q, en_d;
  logic                 en_ref_q, en_ref_d;
  logic                 en_read_q, en_read_d;
  logic [WORD_W-1:0]    ref_32_q, ref_32_d;
  logic [WORD_W-1:0]    read_32_q, read_32_d;
  logic                 done_q, done_d;
  logic                 ref_ready_q, ref_ready_d;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0]    fifo_head;

  dna_word_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ref_valid_i && ref_ready_o),
    .data_i  (ref_word_i),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    word_left_d  = word_left_q;
    sym_cnt_d    = sym_cnt_q;
    first_step_d = first_step_q;
    ref_32_d     = ref_32_q;
    read_32_d    = read_32_q;
    en_d         = 1'b0;
    en_ref_d     = 1'b0;
    en_read_d    = 1'b0;
    fifo_pop     = 1'b0;
    ref_ready_d  = 1'b1;
    done_d       = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ref_words_i == '0) begin
            state_d = DONE;
          end else begin
            state_d     = LOAD;
            word_left_d = ref_words_i;
          end
        end
      end
      LOAD: begin
        if (read_valid_i) begin
          read_32_d    = read_word_i;
          sym_cnt_d    = '0;
          first_step_d = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        // Word boundary with nothing queued: hold everything until a word arrives.
        if (!(sym_cnt_q == '0 && fifo_empty)) begin
          en_d = 1'b1;
          if (sym_cnt_q == '0) begin
            fifo_pop     = 1'b1;
            ref_32_d     = fifo_head;
            en_ref_d     = 1'b1;
            en_read_d    = first_step_q;
            first_step_d = 1'b0;
          end
          sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
          if (sym_cnt_q == '1) begin
            word_left_d = word_left_q - LEN_W'(1);
            if (word_left_q == LEN_W'(1)) state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_left_q  <= '0;
      sym_cnt_q    <= '0;
      first_step_q <= 1'b0;
      en_q         <= 1'b0;
      en_ref_q     <= 1'b0;
      en_read_q    <= 1'b0;
      ref_32_q     <= '0;
      read_32_q    <= '0;
      done_q       <= 1'b0;
      ref_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_left_q  <= word_left_d;
      sym_cnt_q    <= sym_cnt_d;
      first_step_q <= first_step_d;
      en_q         <= en_d;
      en_ref_q     <= en_ref_d;
      en_read_q    <= en_read_d;
      ref_32_q     <= ref_32_d;
      read_32_q    <= read_32_d;
      done_q       <= done_d;
      ref_ready_q  <= ref_ready_d;
    end
  end

`ifdef DNA_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_run;

  always_comb begin
    stall_run   = (state_q == RUN) && (sym_cnt_q == '0) && fifo_empty;
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start_i) begin
      stall_cnt_d = '0;
    end else if (stall_run && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  // ref_ready_q keeps ready low while in reset so every output reads 0 there.
  assign ref_ready_o  = ref_ready_q && !fifo_full;
  assign read_ready_o = (state_q == LOAD);
  assign busy_o       = (state_q != IDLE);
  assign en_o         = en_q;
  assign en_ref_o     = en_ref_q;
  assign en_read_o    = en_read_q;
  assign ref_32_o     = ref_32_q;
  assign read_32_o    = read_32_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_dna_word_feeder.sv
// Scoreboard bench for dna_word_feeder: expected symbol steps queued at stimulus, checked per en_o.
module tb_dna_word_feeder;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [LEN_W-1:0] ref_words_i;
  logic [31:0]      ref_word_i;
  logic             ref_valid_i;
  logic             ref_ready_o;
  logic [31:0]      read_word_i;
  logic             read_valid_i;
  logic             read_ready_o;
  logic             en_o, en_ref_o, en_read_o;
  logic [31:0]      ref_32_o, read_32_o;
  logic             busy_o, done_o;
`ifdef DNA_FEEDER_STALL_CNT_EN
  logic [31:0]      stall_cnt_o;
`endif

  always #5 clk = ~clk;

  dna_word_feeder #(
    .FIFO_DEPTH(8),
    .LEN_W(LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .ref_words_i  (ref_words_i),
    .ref_word_i   (ref_word_i),
    .ref_valid_i  (ref_valid_i),
    .ref_ready_o  (ref_ready_o),
    .read_word_i  (read_word_i),
    .read_valid_i (read_valid_i),
    .read_ready_o (read_ready_o),
    .en_o         (en_o),
    .en_ref_o     (en_ref_o),
    .en_read_o    (en_read_o),
    .ref_32_o     (ref_32_o),
    .read_32_o    (read_32_o),
    .busy_o       (busy_o),
`ifdef DNA_FEEDER_STALL_CNT_EN
    .stall_cnt_o  (stall_cnt_o),
`endif
    .done_o       (done_o)
  );

  typedef struct {
    logic [31:0] word;
    logic        en_ref;
    logic        en_read;
    logic [31:0] rd;
  } step_t;

  step_t       exp_q[$];
  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;
  int unsigned en_total  = 0;
  int unsigned gap_total = 0;
  bit          seen_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic first, input logic [31:0] rd);
    step_t s;
    for (int i = 0; i < 16; i++) begin
      s.word    = w;
      s.en_ref  = (i == 0);
      s.en_read = first && (i == 0);
      s.rd      = rd;
      exp_q.push_back(s);
    end
  endtask

  // Called at a negedge; returns at a negedge after the word transferred.
  task automatic push_word(input logic [31:0] w);
    int unsigned n = 0;
    ref_word_i  = w;
    ref_valid_i = 1'b1;
    while (!ref_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_ready", ref_ready_o, 1);
    @(negedge clk);
    ref_valid_i = 1'b0;
  endtask

  task automatic start_job(input logic [LEN_W-1:0] n, input logic [31:0] rd);
    int unsigned k = 0;
    start_i     = 1'b1;
    ref_words_i = n;
    @(negedge clk);
    start_i = 1'b0;
    while (!read_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("read_ready", read_ready_o, 1);
    read_word_i  = rd;
    read_valid_i = 1'b1;
    @(negedge clk);
    read_valid_i = 1'b0;
  endtask

  task automatic finish_job(input int unsigned n_words, input int unsigned exp_gap,
                            input int unsigned en_base, input int unsigned gap_base);
    int unsigned k    = 0;
    logic        prev = 1'b0;
    while (!done_o && k < 3000) begin
      prev = en_o;
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", done_o, 1);
    check_eq("done_after_last_en", prev, 1);
    #1;
    check_eq("en_count", en_total - en_base, 16 * n_words);
    check_eq("en_gap", gap_total - gap_base, exp_gap);
    check_eq("sb_drained", exp_q.size(), 0);
    @(negedge clk);
    check_eq("done_one_cycle", done_o, 0);
    check_eq("idle_after_done", busy_o, 0);
  endtask

  task automatic wait_en(input int unsigned target);
    int unsigned k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (en_total != target && k < 1000);
    check_eq("en_sync", en_total, target);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_en"}, {en_o, en_ref_o, en_read_o}, 0);
    check_eq({tag, "_ref32"}, ref_32_o, 0);
    check_eq({tag, "_read32"}, read_32_o, 0);
    check_eq({tag, "_ctl"}, {busy_o, done_o, read_ready_o, ref_ready_o}, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seen_en = 1'b0;
    end else begin
      if (en_o) begin
        step_t e;
        en_total++;
        seen_en = 1'b1;
        if (exp_q.size() == 0) begin
          check_eq("en_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("ref_32", ref_32_o, e.word);
          check_eq("en_ref", en_ref_o, e.en_ref);
          check_eq("en_read", en_read_o, e.en_read);
          check_eq("read_32", read_32_o, e.rd);
        end
      end else begin
        check_eq("en_sub_without_en", {en_ref_o, en_read_o}, 0);
        if (busy_o && seen_en) gap_total++;
      end
      if (!busy_o) seen_en = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned eb, gb;
    rst = 1'b1; start_i = 1'b0; ref_words_i = '0; ref_word_i = '0;
    ref_valid_i = 1'b0; read_word_i = '0; read_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two prefetched words, contiguous 32 steps
    push_word(32'hA5A5A5A5);
    push_word(32'h3C3C3C3C);
    expect_word(32'hA5A5A5A5, 1'b1, 32'h12345678);
    expect_word(32'h3C3C3C3C, 1'b0, 32'h12345678);
    eb = en_total; gb = gap_total;
    start_job(2, 32'h12345678);
    finish_job(2, 0, eb, gb);

    // Second word arrives 10 cycles late
    push_word(32'h11112222);
    expect_word(32'h11112222, 1'b1, 32'hCAFEF00D);
    expect_word(32'h33334444, 1'b0, 32'hCAFEF00D);
    expect_word(32'h55556666, 1'b0, 32'hCAFEF00D);
    eb = en_total; gb = gap_total;
    fork
      begin
        start_job(3, 32'hCAFEF00D);
        finish_job(3, 10, eb, gb);
      end
      begin
        wait_en(eb + 16);
        repeat (9) @(negedge clk);
        push_word(32'h33334444);
        push_word(32'h55556666);
      end
    join
`ifdef DNA_FEEDER_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt_o, 10);
`endif

    // Fill to depth, ninth word waits for a pop
    for (int i = 0; i < 8; i++) begin
      push_word(32'hF0000000 + 32'(i));
      expect_word(32'hF0000000 + 32'(i), i == 0, 32'h0BADBEEF);
    end
    check_eq("ready_low_full", ref_ready_o, 0);
    expect_word(32'h99999999, 1'b0, 32'h0BADBEEF);
    eb = en_total; gb = gap_total;
    fork
      push_word(32'h99999999);
      begin
        repeat (3) @(negedge clk);
        check_eq("ready_held_full", ref_ready_o, 0);
        start_job(9, 32'h0BADBEEF);
        finish_job(9, 0, eb, gb);
      end
    join

    // Zero-length job
    eb = en_total;
    start_i = 1'b1; ref_words_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    check_eq("zero_state1", {busy_o, done_o, read_ready_o}, 3'b100);
    @(negedge clk);
    check_eq("zero_state2", {busy_o, done_o, read_ready_o}, 3'b010);
    @(negedge clk);
    check_eq("zero_state3", {busy_o, done_o, read_ready_o}, 3'b000);
    #1;
    check_eq("zero_no_en", en_total, eb);
    @(negedge clk);

    // Reset at step 7 of the first word, then a fresh job
    push_word(32'hDEADBEEF);
    push_word(32'h0F0F0F0F);
    for (int i = 0; i < 8; i++) begin
      step_t s;
      s.word = 32'hDEADBEEF; s.en_ref = (i == 0); s.en_read = (i == 0); s.rd = 32'h77777777;
      exp_q.push_back(s);
    end
    eb = en_total;
    start_job(2, 32'h77777777);
    wait_en(eb + 8);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    check_eq("midrst_sb", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    push_word(32'h24682468);
    expect_word(32'h24682468, 1'b1, 32'h13571357);
    eb = en_total; gb = gap_total;
    start_job(1, 32'h13571357);
    finish_job(1, 0, eb, gb);

    // start_i during RUN is ignored
    push_word(32'hAAAA5555);
    push_word(32'h5555AAAA);
    expect_word(32'hAAAA5555, 1'b1, 32'h0000FFFF);
    expect_word(32'h5555AAAA, 1'b0, 32'h0000FFFF);
    eb = en_total; gb = gap_total;
    fork
      begin
        start_job(2, 32'h0000FFFF);
        finish_job(2, 0, eb, gb);
      end
      begin
        wait_en(eb + 5);
        @(negedge clk);
        start_i = 1'b1; ref_words_i = 16'd5;
        @(negedge clk);
        start_i = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check_eq("no_restart", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
